serial_frame_ctrl: RTL and testbench

//   Upstream sequencer for the 48-bit serial shifter. Latches a 6-byte frame on start.

---
 rtl/serial_frame_ctrl_if.sv | 27 ++
 rtl/serial_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_ctrl_if.sv
// Host/shifter bundle for serial_frame_ctrl.
// The hold signal exists only when SERIAL_HOLD_EN is defined.
interface serial_frame_ctrl_if;
  logic [47:0] frame;
  logic        start;
`ifdef SERIAL_HOLD_EN
  logic        hold;
`endif
  logic [7:0]  data;
  logic [2:0]  sel;
  logic        get;
  logic        send;
  logic        busy;
  logic        done;

`ifdef SERIAL_HOLD_EN
  modport master (output frame, start, hold,
                  input  data, sel, get, send, busy, done);
  modport slave  (input  frame, start, hold,
                  output data, sel, get, send, busy, done);
`else
  modport master (output frame, start,
                  input  data, sel, get, send, busy, done);
  modport slave  (input  frame, start,
                  output data, sel, get, send, busy, done);
`endif
endinterface

// File: rtl/serial_frame_ctrl.sv
// Upstream sequencer for the 48-bit serial shifter: latches a 6-byte frame,
// writes it byte by byte (get/sel/data), then paces 48 send strobes at the
// bit rate. Optional bit-pacing pause via hold when SERIAL_HOLD_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, frame input sampled here only
// LOAD  | one get per cycle, sel 0..5
// SHIFT | baud pacing, one send per BAUD_DIV cycles, 48 sends
// DONE  | single-cycle done pulse
module serial_frame_ctrl #(
  parameter int BAUD_DIV  = 434,
  parameter int NUM_BYTES = 6
) (
  input  logic                clk,
  input  logic                nRst,
  serial_frame_ctrl_if.slave  bus
);

  localparam int              BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]      SEL_LAST  = 3'(NUM_BYTES - 1);
  localparam logic [5:0]      BIT_LAST  = 6'd47;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [47:0]     frame_q, frame_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [BW-1:0]   baud_cnt, baud_nxt;
  logic [5:0]      bit_cnt, bit_nxt;
  logic            freeze;

  logic [7:0]      data_nxt;
  logic [2:0]      sel_nxt;
  logic            get_nxt, send_nxt, busy_nxt, done_nxt;

`ifdef SERIAL_HOLD_EN
  assign freeze = bus.hold;
`else
  assign freeze = 1'b0;
`endif

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= S_IDLE;
      frame_q  <= '0;
      idx      <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      bus.data <= '0;
      bus.sel  <= '0;
      bus.get  <= 1'b0;
      bus.send <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nxt;
      frame_q  <= frame_nxt;
      idx      <= idx_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      bus.data <= data_nxt;
      bus.sel  <= sel_nxt;
      bus.get  <= get_nxt;
      bus.send <= send_nxt;
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
    end
  end

  // Next state and counter updates.
  always_comb begin
    state_nxt = state;
    frame_nxt = frame_q;
    idx_nxt   = idx;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          frame_nxt = bus.frame;
          idx_nxt   = '0;
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (idx == SEL_LAST) begin
          idx_nxt   = '0;
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = S_SHIFT;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      S_SHIFT: begin
        // A frozen counter sitting at BAUD_LAST has already emitted its send;
        // it wraps once hold drops, stretching that bit period.
        if (!freeze) begin
          if (baud_cnt == BAUD_LAST) begin
            baud_nxt = '0;
            if (bit_cnt == BIT_LAST) begin
              bit_nxt   = '0;
              state_nxt = S_DONE;
            end else begin
              bit_nxt = bit_cnt + 6'd1;
            end
          end else begin
            baud_nxt = baud_cnt + BW'(1);
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from next state and counters.
  always_comb begin
    get_nxt  = (state_nxt == S_LOAD);
    sel_nxt  = get_nxt ? idx_nxt : 3'd0;
    data_nxt = get_nxt ? frame_nxt[{idx_nxt, 3'b000} +: 8] : 8'd0;
    send_nxt = (state_nxt == S_SHIFT) && !freeze && (baud_nxt == BAUD_LAST);
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Self-checking bench for serial_frame_ctrl with BAUD_DIV=4.
module tb_serial_frame_ctrl;

  localparam int B         = 4;
  localparam int FRAME_LEN = 6 + 48*B + 1;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  serial_frame_ctrl_if bus();

  serial_frame_ctrl #(.BAUD_DIV(B), .NUM_BYTES(6)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [14:0] obs[$];
  logic [14:0] abort_obs;
  logic        tx_bits[$];
`ifdef SERIAL_HOLD_EN
  int          hold_at_g = 0;
`endif

  // Output bundle layout: {data[14:7], sel[6:4], get[3], send[2], busy[1], done[0]}
  function automatic logic [14:0] cur_out();
    return {bus.data, bus.sel, bus.get, bus.send, bus.busy, bus.done};
  endfunction

  // Expected outputs t cycles after the start-accepting edge; hs = hold stretch
  // applied to the gap before bit 10.
  function automatic logic [14:0] exp_out(int t, logic [47:0] f, int hs);
    int         t_done;
    logic       g;
    logic       s;
    logic [7:0] d;
    logic [2:0] sl;
    t_done = FRAME_LEN + hs;
    g  = (t >= 1) && (t <= 6);
    s  = 1'b0;
    d  = 8'd0;
    sl = 3'd0;
    if (g) begin
      sl = 3'(t - 1);
      d  = 8'(f >> (8*(t-1)));
    end
    for (int k = 0; k < 48; k++)
      if (t == 6 + B*(k+1) + ((k >= 10) ? hs : 0)) s = 1'b1;
    return {d, sl, g, s, (t >= 1) && (t <= t_done), (t == t_done)};
  endfunction

  // Drives one frame from an idle negedge, captures outputs each cycle and
  // feeds a model of the downstream shifter collecting tx bits.
  task automatic drive_frame(input logic [47:0] f, input int ncyc,
                             input int mid_at, input int abort_at);
    logic [47:0] sh;
    logic [14:0] o;
    sh = '0;
    obs.delete();
    tx_bits.delete();
    bus.frame = f;
    bus.start = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      if (t == abort_at) begin
        nRst = 1'b0;
        bus.start = 1'b0;
        #1;
        abort_obs = cur_out();
        return;
      end
      o = cur_out();
      obs.push_back(o);
      if (o[3] && o[6:4] < 3'd6) sh[8*int'(o[6:4]) +: 8] = o[14:7];
      if (o[2]) begin
        tx_bits.push_back(sh[0]);
        sh = sh >> 1;
      end
      bus.start = (t == mid_at);
      if (t == mid_at) bus.frame = 48'({$urandom(), $urandom()});
`ifdef SERIAL_HOLD_EN
      bus.hold = (hold_at_g > 0) && (t >= hold_at_g) && (t < hold_at_g + 10);
`endif
    end
  endtask

  task automatic test_reset();
    nRst = 1'b1;
    bus.start = 1'b0;
    bus.frame = '0;
`ifdef SERIAL_HOLD_EN
    bus.hold = 1'b0;
`endif
    #2 nRst = 1'b0;
    #1;
    n_vec++;
    if (cur_out() !== 15'd0) begin
      n_err++;
      $display("FAIL reset_async got=%h exp=%h", cur_out(), 15'd0);
    end
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (cur_out() !== 15'd0) begin
        n_err++;
        $display("FAIL idle_stay cyc=%0d got=%h exp=%h", i, cur_out(), 15'd0);
      end
    end
  endtask

  task automatic test_load_shift();
    logic [47:0] f;
    logic [47:0] w;
    f = 48'h0123456789AB;
    drive_frame(f, FRAME_LEN + 1, 0, 0);
    for (int i = 0; i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== exp_out(i+1, f, 0)) begin
        n_err++;
        $display("FAIL load_shift t=%0d got=%h exp=%h", i+1, obs[i], exp_out(i+1, f, 0));
      end
    end
    w = '0;
    foreach (tx_bits[i]) if (i < 48) w[i] = tx_bits[i];
    n_vec++;
    if (tx_bits.size() != 48 || w !== f) begin
      n_err++;
      $display("FAIL load_shift_tx got=%0d bits %h exp=48 bits %h", tx_bits.size(), w, f);
    end
  endtask

  task automatic test_ignore_start();
    logic [47:0] f;
    logic [47:0] w;
    f = 48'({$urandom(), $urandom()});
    drive_frame(f, FRAME_LEN + 1, 100, 0);
    for (int i = 0; i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== exp_out(i+1, f, 0)) begin
        n_err++;
        $display("FAIL ignore_start t=%0d got=%h exp=%h", i+1, obs[i], exp_out(i+1, f, 0));
      end
    end
    w = '0;
    foreach (tx_bits[i]) if (i < 48) w[i] = tx_bits[i];
    n_vec++;
    if (tx_bits.size() != 48 || w !== f) begin
      n_err++;
      $display("FAIL ignore_start_tx got=%0d bits %h exp=48 bits %h", tx_bits.size(), w, f);
    end
  endtask

  task automatic test_reset_abort();
    logic [47:0] f;
    logic [47:0] w;
    f = 48'({$urandom(), $urandom()});
    drive_frame(f, FRAME_LEN + 1, 0, 6 + B*21 + 2);
    for (int i = 0; i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== exp_out(i+1, f, 0)) begin
        n_err++;
        $display("FAIL abort_pre t=%0d got=%h exp=%h", i+1, obs[i], exp_out(i+1, f, 0));
      end
    end
    n_vec++;
    if (abort_obs !== 15'd0) begin
      n_err++;
      $display("FAIL abort_async got=%h exp=%h", abort_obs, 15'd0);
    end
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cur_out() !== 15'd0) begin
      n_err++;
      $display("FAIL abort_idle got=%h exp=%h", cur_out(), 15'd0);
    end
    f = 48'({$urandom(), $urandom()});
    drive_frame(f, FRAME_LEN + 1, 0, 0);
    for (int i = 0; i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== exp_out(i+1, f, 0)) begin
        n_err++;
        $display("FAIL abort_rerun t=%0d got=%h exp=%h", i+1, obs[i], exp_out(i+1, f, 0));
      end
    end
    w = '0;
    foreach (tx_bits[i]) if (i < 48) w[i] = tx_bits[i];
    n_vec++;
    if (tx_bits.size() != 48 || w !== f) begin
      n_err++;
      $display("FAIL abort_rerun_tx got=%0d bits %h exp=48 bits %h", tx_bits.size(), w, f);
    end
  endtask

`ifdef SERIAL_HOLD_EN
  task automatic test_hold();
    logic [47:0] f;
    logic [47:0] w;
    f = 48'({$urandom(), $urandom()});
    hold_at_g = 6 + B*10;
    drive_frame(f, FRAME_LEN + 10 + 1, 0, 0);
    hold_at_g = 0;
    bus.hold = 1'b0;
    for (int i = 0; i < obs.size(); i++) begin
      n_vec++;
      if (obs[i] !== exp_out(i+1, f, 10)) begin
        n_err++;
        $display("FAIL hold t=%0d got=%h exp=%h", i+1, obs[i], exp_out(i+1, f, 10));
      end
    end
    w = '0;
    foreach (tx_bits[i]) if (i < 48) w[i] = tx_bits[i];
    n_vec++;
    if (tx_bits.size() != 48 || w !== f) begin
      n_err++;
      $display("FAIL hold_tx got=%0d bits %h exp=48 bits %h", tx_bits.size(), w, f);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [47:0] f;
    logic [47:0] w;
    for (int n = 0; n < 3; n++) begin
      f = 48'({$urandom(), $urandom()});
      drive_frame(f, FRAME_LEN + 1, 0, 0);
      for (int i = 0; i < obs.size(); i++) begin
        n_vec++;
        if (obs[i] !== exp_out(i+1, f, 0)) begin
          n_err++;
          $display("FAIL b2b%0d t=%0d got=%h exp=%h", n, i+1, obs[i], exp_out(i+1, f, 0));
        end
      end
      w = '0;
      foreach (tx_bits[i]) if (i < 48) w[i] = tx_bits[i];
      n_vec++;
      if (tx_bits.size() != 48 || w !== f) begin
        n_err++;
        $display("FAIL b2b%0d_tx got=%0d bits %h exp=48 bits %h", n, tx_bits.size(), w, f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_ignore_start();
    test_reset_abort();
`ifdef SERIAL_HOLD_EN
    test_hold();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
